lvds_rx_delay_train: RTL

Training and word-alignment stage that sits directly downstream of the 1:7 LVDS RX deserializer on the clock lane. It consumes the P-path and N-path 7-bit words; the N path is delayed by the deserializer at tap+2. The block drives the shared 8-bit IDELAY code back to the deserializer. It sweeps the delay code, finds the widest stable eye, centres the code in it, then finds the bit rotation that produces the LVDS clock pattern. It outputs the aligned word and a lock flag used by the data-lane receivers.

---
 rtl/lvds_rx_delay_train.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/lvds_rx_delay_train.sv
// Clock-lane IDELAY training and word alignment behind the 1:7 LVDS deserializer.
// Sweeps the delay code, centres it in the widest stable eye, then finds the bit rotation.
module lvds_rx_delay_train #(
  parameter int unsigned TAP_LAST    = 253,
  parameter int unsigned SETTLE_CYC  = 16,
  parameter int unsigned CHECK_CYC   = 64,
  parameter int unsigned MIN_EYE     = 8,
  parameter logic [6:0]  CLK_PATTERN = 7'b1100011,
  parameter int unsigned ERR_LIMIT   = 4
) (
  input  logic       I_clk_1x,
  input  logic       I_rst,
  input  logic       I_train_start,
  input  logic [6:0] I_diff_pdata,
  input  logic [6:0] I_diff_ndata,
  output logic [7:0] O_idelay_num,
  output logic [6:0] O_word,
  output logic       O_word_vld,
  output logic [2:0] O_slip,
  output logic       O_lock,
  output logic       O_train_fail,
  output logic       O_busy
);

  localparam logic [7:0]  TAP_END  = 8'(TAP_LAST);
  localparam logic [15:0] SETTLE_N = 16'(SETTLE_CYC);
  localparam logic [15:0] CHECK_N  = 16'(CHECK_CYC);
  localparam logic [8:0]  EYE_MIN  = 9'(MIN_EYE);
  localparam logic [7:0]  ERR_MAX  = 8'(ERR_LIMIT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_NEXT,
    S_CENTER,
    S_ASETTLE,
    S_ALIGN,
    S_VERIFY,
    S_LOCKED,
    S_FAIL
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [15:0] settle_cnt;
  logic [15:0] check_cnt;
  logic [7:0]  tap;
  logic        tap_good;
  logic [7:0]  cur_start;
  logic [8:0]  cur_len;
  logic [7:0]  best_start;
  logic [8:0]  best_len;
  logic [7:0]  err_cnt;

  logic [6:0]  word_rot;
  logic        word_bad;
  logic        err_hit;
  logic        restart;
  logic        al_hit;
  logic [2:0]  al_rot;
  logic [8:0]  run_len;
  logic [7:0]  run_start;
  logic        run_close;
  logic [8:0]  center;

  function automatic logic [6:0] rotl(
    input logic [6:0] d,
    input logic [2:0] r
  );
    logic [13:0] dd;
    dd = {d, d} << r;
    return dd[13:7];
  endfunction

  assign word_rot = rotl(I_diff_pdata, O_slip);
  assign word_bad = word_rot != CLK_PATTERN;
  assign err_hit  = (state == S_LOCKED) && word_bad
                    && (err_cnt == ERR_MAX);
  assign restart  = I_train_start || err_hit;

  // A good tap opens a run if none is open; the last tap always closes it.
  assign run_len   = tap_good ? cur_len + 9'd1 : cur_len;
  assign run_start = (tap_good && cur_len == 9'd0) ? tap : cur_start;
  assign run_close = !tap_good || (tap == TAP_END);
  assign center    = {1'b0, best_start} + {1'b0, best_len[8:1]};

  // Scan high to low so the smallest matching rotation wins.
  always_comb begin
    al_hit = 1'b0;
    al_rot = 3'd0;
    for (int r = 6; r >= 0; r--) begin
      if (rotl(I_diff_pdata, 3'(r)) == CLK_PATTERN) begin
        al_hit = 1'b1;
        al_rot = 3'(r);
      end
    end
  end

  always_ff @(posedge I_clk_1x or posedge I_rst) begin
    if (I_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (restart) begin
      state_nxt = S_SETTLE;
    end else begin
      unique case (state)
        S_IDLE: begin
        end
        S_SETTLE: begin
          if (settle_cnt <= 16'd1) state_nxt = S_CHECK;
        end
        S_CHECK: begin
          if (check_cnt <= 16'd1) state_nxt = S_NEXT;
        end
        S_NEXT: begin
          state_nxt = (tap == TAP_END) ? S_CENTER : S_SETTLE;
        end
        S_CENTER: begin
          state_nxt = (best_len < EYE_MIN) ? S_FAIL : S_ASETTLE;
        end
        S_ASETTLE: begin
          if (settle_cnt <= 16'd1) state_nxt = S_ALIGN;
        end
        S_ALIGN: begin
          state_nxt = al_hit ? S_VERIFY : S_FAIL;
        end
        S_VERIFY: begin
          if (word_bad) state_nxt = S_FAIL;
          else if (check_cnt <= 16'd1) state_nxt = S_LOCKED;
        end
        S_LOCKED: begin
        end
        S_FAIL: begin
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge I_clk_1x or posedge I_rst) begin
    if (I_rst) begin
      settle_cnt   <= '0;
      check_cnt    <= '0;
      tap          <= '0;
      tap_good     <= 1'b0;
      cur_start    <= '0;
      cur_len      <= '0;
      best_start   <= '0;
      best_len     <= '0;
      err_cnt      <= '0;
      O_idelay_num <= '0;
      O_word       <= '0;
      O_word_vld   <= 1'b0;
      O_slip       <= '0;
      O_lock       <= 1'b0;
      O_train_fail <= 1'b0;
      O_busy       <= 1'b0;
    end else if (restart) begin
      settle_cnt   <= SETTLE_N;
      check_cnt    <= CHECK_N;
      tap          <= '0;
      tap_good     <= 1'b1;
      cur_start    <= '0;
      cur_len      <= '0;
      best_start   <= '0;
      best_len     <= '0;
      err_cnt      <= '0;
      O_idelay_num <= '0;
      O_word_vld   <= 1'b0;
      O_lock       <= 1'b0;
      O_train_fail <= 1'b0;
      O_busy       <= 1'b1;
    end else begin
      unique case (state)
        S_SETTLE, S_ASETTLE: begin
          settle_cnt <= settle_cnt - 16'd1;
          check_cnt  <= CHECK_N;
          tap_good   <= 1'b1;
        end
        S_CHECK: begin
          check_cnt <= check_cnt - 16'd1;
          if (I_diff_pdata != I_diff_ndata) tap_good <= 1'b0;
        end
        S_NEXT: begin
          if (run_close) begin
            if (run_len > best_len) begin
              best_start <= run_start;
              best_len   <= run_len;
            end
            cur_len <= '0;
          end else begin
            cur_len   <= run_len;
            cur_start <= run_start;
          end
          if (tap != TAP_END) begin
            tap          <= tap + 8'd1;
            O_idelay_num <= tap + 8'd1;
            settle_cnt   <= SETTLE_N;
          end
        end
        S_CENTER: begin
          if (best_len >= EYE_MIN) begin
            O_idelay_num <= center[7:0];
            settle_cnt   <= SETTLE_N;
          end
        end
        S_ALIGN: begin
          if (al_hit) O_slip <= al_rot;
        end
        S_VERIFY: begin
          check_cnt <= check_cnt - 16'd1;
          if (!word_bad && check_cnt <= 16'd1) begin
            O_lock <= 1'b1;
            O_busy <= 1'b0;
          end
        end
        S_LOCKED: begin
          O_word     <= word_rot;
          O_word_vld <= 1'b1;
          err_cnt    <= word_bad ? err_cnt + 8'd1 : 8'd0;
        end
        default: begin
        end
      endcase
      if (state_nxt == S_FAIL && state != S_FAIL) begin
        O_train_fail <= 1'b1;
        O_lock       <= 1'b0;
        O_busy       <= 1'b0;
        O_idelay_num <= '0;
      end
    end
  end

endmodule
